// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART definitions: FSM state encoding, parity modes and a
//            frame-length helper for benches.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // 3-bit state encoding shared by the TX engine (and later the RX side)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP,
    S_DONE   = ST_DONE
  } tx_state_t;

  // Parity mode selector values
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Frame length in bit times; pass clks_per_bit to get clock cycles instead
  function automatic int frame_clks(input int data_bits, input int parity,
                                    input int stop_bits, input int clks_per_bit = 1);
    return (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * clks_per_bit;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Purpose  : Bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled and
//            flags the last cycle of each bit period with bit_tick.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // Clear dominates enable so a fresh bit period always starts at zero
  assign bit_tick = enable && !clear && (count == LAST_CNT);

  // Bit-period counter with synchronous reset and clear
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST_CNT) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule : uart_baud_gen
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_engine
// Purpose  : UART transmitter. Frames a UDR byte as start, LSB-first data,
//            optional parity and stop bit(s); reports completion with a done
//            level that is held until tx_start is released.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_tx,
  input  logic                 en_udr,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 tx_start,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam logic       HAS_PARITY = (PARITY != PAR_NONE);
  localparam logic       ODD_FLAG   = (PARITY == PAR_ODD);
  localparam logic [2:0] DATA_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST  = 3'(STOP_BITS - 1);

  tx_state_t              state, state_next;
  logic [DATA_BITS-1:0]   udr;
  logic [DATA_BITS-1:0]   shreg, shreg_next;
  logic                   par_bit, par_next;
  logic [2:0]             bit_idx, bit_idx_next;
  logic                   tx_next, busy_next, done_next;
  logic                   baud_en, baud_clr, bit_tick;

  // Counter runs only while a bit is on the line; an abort clears it at once
  assign baud_en  = (state == S_START) || (state == S_DATA) ||
                    (state == S_PARITY) || (state == S_STOP);
  assign baud_clr = !en_tx || !baud_en;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (baud_clr),
    .enable  (baud_en),
    .bit_tick(bit_tick)
  );

  // UDR accepts a new byte only while idle so the byte in flight is stable
  always_ff @(posedge clk) begin
    if (reset) begin
      udr <= '0;
    end else if (en_udr && (state == S_IDLE)) begin
      udr <= din;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    par_next     = par_bit;
    bit_idx_next = bit_idx;
    tx_next      = 1'b1;
    busy_next    = 1'b0;
    done_next    = 1'b0;

    if (!en_tx) begin
      state_next   = S_IDLE;
      bit_idx_next = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tx_start) begin
            // Bypass: a byte written in the same cycle goes straight out
            shreg_next   = en_udr ? din : udr;
            par_next     = (^shreg_next) ^ ODD_FLAG;
            bit_idx_next = '0;
            state_next   = S_START;
          end
        end
        S_START: begin
          if (bit_tick) begin
            bit_idx_next = '0;
            state_next   = S_DATA;
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            if (bit_idx == DATA_LAST) begin
              bit_idx_next = '0;
              state_next   = HAS_PARITY ? S_PARITY : S_STOP;
            end else begin
              bit_idx_next = bit_idx + 3'd1;
              shreg_next   = shreg >> 1;
            end
          end
        end
        S_PARITY: begin
          if (bit_tick) begin
            bit_idx_next = '0;
            state_next   = S_STOP;
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            if (bit_idx == STOP_LAST) begin
              bit_idx_next = '0;
              state_next   = S_DONE;
            end else begin
              bit_idx_next = bit_idx + 3'd1;
            end
          end
        end
        S_DONE: begin
          // Held tx_start keeps us here, so it can never retrigger a frame
          if (!tx_start) begin
            state_next = S_IDLE;
          end
        end
        default: begin
          state_next   = S_IDLE;
          bit_idx_next = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state and registered below
    case (state_next)
      S_START: begin
        tx_next   = 1'b0;
        busy_next = 1'b1;
      end
      S_DATA: begin
        tx_next   = shreg_next[0];
        busy_next = 1'b1;
      end
      S_PARITY: begin
        tx_next   = par_next;
        busy_next = 1'b1;
      end
      S_STOP: begin
        busy_next = 1'b1;
      end
      S_DONE: begin
        done_next = 1'b1;
      end
      default: begin
        tx_next = 1'b1;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Shift register, parity bit and bit index
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      par_bit <= 1'b0;
      bit_idx <= '0;
    end else begin
      shreg   <= shreg_next;
      par_bit <= par_next;
      bit_idx <= bit_idx_next;
    end
  end

  // Registered line and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      tx   <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      tx   <= tx_next;
      busy <= busy_next;
      done <= done_next;
    end
  end

endmodule : uart_tx_engine
`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_engine
// Purpose  : Directed self-checking bench for uart_tx_engine. Four instances
//            share one stimulus: (parity,stop) = (none,1) (even,1) (odd,1)
//            (odd,2), all with CLKS_PER_BIT=4 and DATA_BITS=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_engine;

  logic       clk = 1'b0;
  logic       reset, en_tx, en_udr, tx_start;
  logic [7:0] din;
  logic [3:0] tx_w, busy_w, done_w;

  int   checks = 0;
  int   errors = 0;
  int   done_rises = 0;
  logic prev_done0 = 1'b0;
  int   cyc, w, gap;
  logic [7:0] bytes6 [2];

  always #5 clk = ~clk;

  uart_tx_engine #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .en_tx(en_tx), .en_udr(en_udr), .din(din),
    .tx_start(tx_start), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  uart_tx_engine #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .en_tx(en_tx), .en_udr(en_udr), .din(din),
    .tx_start(tx_start), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  uart_tx_engine #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut2 (
    .clk(clk), .reset(reset), .en_tx(en_tx), .en_udr(en_udr), .din(din),
    .tx_start(tx_start), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  uart_tx_engine #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut3 (
    .clk(clk), .reset(reset), .en_tx(en_tx), .en_udr(en_udr), .din(din),
    .tx_start(tx_start), .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

  // Per-instance configuration
  function automatic int par_of(input int k);
    case (k)
      0:       return 0;
      1:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int stp_of(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  function automatic int flen(input int k);
    return 4 * (1 + 8 + ((par_of(k) != 0) ? 1 : 0) + stp_of(k));
  endfunction

  // Expected line level at sample i (i=0 is the cycle after the start edge)
  function automatic logic exp_tx(input int k, input logic [7:0] b, input int i);
    int s;
    s = i / 4;
    if (i >= flen(k)) return 1'b1;
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
    if ((s == 9) && (par_of(k) != 0)) return (^b) ^ (par_of(k) == 2);
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    if (done_w[0] && !prev_done0) done_rises++;
    prev_done0 = done_w[0];
  endtask

  task automatic chk_idle(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s d%0d tx", tag, k), 32'(tx_w[k]), 32'd1);
      chk($sformatf("%s d%0d busy", tag, k), 32'(busy_w[k]), 32'd0);
      chk($sformatf("%s d%0d done", tag, k), 32'(done_w[k]), 32'd0);
    end
  endtask

  // Caller has raised tx_start; check n samples of all instances
  task automatic run_frame(input string tag, input logic [7:0] b, input int n,
                           input int poke_i, input logic [7:0] poke_d);
    for (int i = 0; i < n; i++) begin
      tick();
      en_udr = 1'b0;
      if (i == poke_i) begin
        en_udr = 1'b1;
        din    = poke_d;
      end
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("%s d%0d tx i%0d", tag, k, i), 32'(tx_w[k]), 32'(exp_tx(k, b, i)));
        chk($sformatf("%s d%0d busy i%0d", tag, k, i), 32'(busy_w[k]), 32'(i < flen(k)));
        chk($sformatf("%s d%0d done i%0d", tag, k, i), 32'(done_w[k]), 32'(i >= flen(k)));
      end
    end
    en_udr = 1'b0;
  endtask

  // Release tx_start: done drops next edge and no second frame follows
  task automatic finish_frame(input string tag);
    tx_start = 1'b0;
    tick();
    chk_idle({tag, " undone"});
    tick();
    tick();
    chk_idle({tag, " stay"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; en_tx = 1'b0; en_udr = 1'b0; tx_start = 1'b0; din = 8'h00;
    tick(); tick();
    chk_idle("reset");
    reset = 1'b0; en_tx = 1'b1;
    tick();
    chk_idle("idle");

    // 1: UDR-loaded 0xA5, tx_start held through DONE
    en_udr = 1'b1; din = 8'hA5;
    tick();
    chk_idle("t1 load");
    en_udr = 1'b0; din = 8'h00; tx_start = 1'b1;
    run_frame("t1", 8'hA5, 52, -1, 8'h00);
    finish_frame("t1");

    // 2: bypass 0x07 in the start cycle (even/odd parity instances)
    en_udr = 1'b1; din = 8'h07; tx_start = 1'b1;
    run_frame("t2", 8'h07, 52, -1, 8'h00);
    finish_frame("t2");

    // 3: 0xFF
    en_udr = 1'b1; din = 8'hFF;
    tick();
    en_udr = 1'b0; tx_start = 1'b1;
    run_frame("t3", 8'hFF, 52, -1, 8'h00);
    finish_frame("t3");

    // 4: UDR write during DATA is ignored; new value only after IDLE reload
    tx_start = 1'b1;
    run_frame("t4a", 8'hFF, 52, 10, 8'h3C);
    finish_frame("t4a");
    tx_start = 1'b1;
    run_frame("t4b", 8'hFF, 52, -1, 8'h3C);
    finish_frame("t4b");
    en_udr = 1'b1; din = 8'h3C;
    tick();
    en_udr = 1'b0; tx_start = 1'b1;
    run_frame("t4c", 8'h3C, 52, -1, 8'h00);
    finish_frame("t4c");

    // 5: en_tx abort at cycle 15, then reset at cycle 22 of a fresh frame
    en_udr = 1'b1; din = 8'h55;
    tick();
    en_udr = 1'b0; tx_start = 1'b1;
    run_frame("t5a", 8'h55, 14, -1, 8'h00);
    en_tx = 1'b0;
    tick();
    chk_idle("t5 abort");
    tick(); tick();
    chk_idle("t5 disabled");
    en_tx = 1'b1;
    run_frame("t5b", 8'h55, 21, -1, 8'h00);
    reset = 1'b1;
    tick();
    chk_idle("t5 reset");
    reset = 1'b0; tx_start = 1'b0;
    tick();
    chk_idle("t5 post");
    tx_start = 1'b1;
    run_frame("t5c", 8'h00, 52, -1, 8'h00);
    finish_frame("t5c");

    // 6: controller-style back-to-back bytes on the no-parity instance
    bytes6[0] = 8'h12; bytes6[1] = 8'h34;
    done_rises = 0; prev_done0 = done_w[0]; gap = 0;
    for (int f = 0; f < 2; f++) begin
      en_udr = 1'b1; din = bytes6[f];
      tick();
      en_udr = 1'b0;
      if (tx_w[0] && !busy_w[0] && !done_w[0]) gap++;
      if (f == 1) chk("t6 idle gap", 32'(gap >= 2), 32'd1);
      tx_start = 1'b1;
      cyc = 0;
      do begin
        tick();
        cyc++;
        chk($sformatf("t6 f%0d tx i%0d", f, cyc - 1), 32'(tx_w[0]), 32'(exp_tx(0, bytes6[f], cyc - 1)));
        chk($sformatf("t6 f%0d busy i%0d", f, cyc - 1), 32'(busy_w[0]), 32'(cyc - 1 < 40));
      end while (!done_w[0] && cyc < 200);
      chk($sformatf("t6 f%0d done cycle", f), 32'(cyc), 32'd41);
      tx_start = 1'b0;
      w = 0;
      do begin
        tick();
        w++;
      end while (done_w[0] && w < 20);
      chk($sformatf("t6 f%0d undone latency", f), 32'(w), 32'd1);
      gap = (tx_w[0] && !busy_w[0]) ? 1 : 0;
    end
    tick(); tick(); tick();
    chk("t6 tail idle tx", 32'(tx_w[0]), 32'd1);
    chk("t6 tail busy", 32'(busy_w[0]), 32'd0);
    chk("t6 done pulses", 32'(done_rises), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx_engine
`default_nettype wire

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Serial transmitter directly downstream of the AES-over-UART TX controller.
- Each byte unloaded from the PISO passes through the UART data register (UDR) into this block. The block frames the byte as start, data LSB-first, optional parity and stop bit(s), then shifts it onto the serial line.
- It reports completion through a done level that follows the controller's start/done/un-done handshake.

Parameters:
CLKS_PER_BIT, 5208, clk cycles per serial bit (50 MHz / 9600 baud); legal range 2..65535
DATA_BITS, 8, data bits per frame; legal range 5..8
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame; 1 or 2

Ports:
clk  input  1  global clock
reset  input  1  synchronous, active-high reset
en_tx  input  1  transmitter enable; low forces the line idle and aborts any frame
en_udr  input  1  load din into the UDR
din  input  DATA_BITS  byte to transmit
tx_start  input  1  level request to send the UDR contents
tx  output  1  serial line, idle high, registered
busy  output  1  high from the first start-bit cycle through the last stop-bit cycle
done  output  1  frame complete; held until tx_start is seen low

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: tx=1, busy=0, done=0, UDR=0, state=IDLE, baud counter=0, bit index=0.
  - Reset has priority over every other input.
  - Reset mid-frame returns tx to 1 on the next edge, with no partial bits.
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 inside START, DATA, PARITY and STOP.
  - bit_tick is asserted when the count equals CLKS_PER_BIT-1; the count then wraps to 0.
  - In IDLE and DONE the counter is cleared.
- UDR:
  - Loads din on en_udr only while in IDLE.
  - en_udr is ignored in every other state, so the byte in flight never changes.
- IDLE:
  - tx=1.
  - If en_tx and tx_start are both high: capture the shift register and go to START.
  - The shift register takes din if en_udr is high in the same cycle (bypass); otherwise it takes the UDR.
  - Parity is computed over the captured byte.
- Frame timing:
  - tx goes low on the first edge after tx_start is sampled high; latency is 1 cycle.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: shift LSB first, DATA_BITS bits of CLKS_PER_BIT cycles each, bit index 0..DATA_BITS-1.
  - PARITY (only when PARITY != 0): one bit time. Even parity gives the XOR of the data; odd parity gives its inverse.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - Total frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- DONE:
  - Entered on the edge after the last stop-bit cycle; busy=0, done=1, tx=1.
  - Stays in DONE while tx_start=1. A held tx_start must never retrigger a frame.
  - When tx_start=0 is sampled: done=0 next edge, go to IDLE.
  - A new frame can start no earlier than the cycle after IDLE is re-entered.
- en_tx low:
  - In any non-IDLE state: abort to IDLE on the next edge with tx=1, busy=0, done=0.
  - In IDLE: tx_start is ignored.
- Simultaneous events:
  - Reset outranks en_tx, which outranks tx_start.
  - A tx_start that rises during busy is ignored.
- Illegal or unreached state encodings recover to IDLE with the reset output values.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding localparams (IDLE..DONE, 3 bits);
  - the parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - a function frame_clks(DATA_BITS, PARITY, STOP_BITS) for benches.
- One sub-module, uart_baud_gen: a counter with clear/enable producing bit_tick. It is reused later by the RX side.
- Shift register, parity and FSM stay in uart_tx_engine.

Test Plan (CLKS_PER_BIT=4, DATA_BITS=8 unless stated):
1. PARITY=0, STOP_BITS=1; en_tx=1, en_udr=1 with din=0xA5, then tx_start=1 held.
   - tx per 4-cycle slot: 0,1,0,1,0,0,1,0,1,1.
   - busy high for 40 cycles; done rises on cycle 41 and stays high while tx_start=1.
   - done falls 1 cycle after tx_start drops; no second frame.
2. PARITY=1, din=0x07 bypassed with en_udr and tx_start in the same cycle.
   - Parity slot=1; frame is 44 cycles.
   - Same setup with PARITY=2 gives parity=0.
3. STOP_BITS=2, din=0xFF.
   - tx low only for the 4 start-bit cycles; stop high 8 cycles; done at cycle 49.
4. Mid-frame: en_udr with din=0x3C during DATA.
   - The transmitted byte is unchanged (prior UDR value).
   - After DONE, a new tx_start sends 0x3C only if en_udr is re-asserted in IDLE.
5. Abort cases:
   - en_tx dropped at cycle 15 of a frame: tx=1, busy=0, done=0 next edge.
   - Reset asserted at cycle 22 of another frame: all outputs return to reset values next edge.
6. Back-to-back drive mimicking the controller: two bytes 0x12, 0x34 with the start / wait-done / wait-undone pattern.
   - Two clean 40-cycle frames.
   - At least 2 idle-high cycles between frames.
   - done pulses exactly twice.
